// File: rtl/enc_history_disp.sv
// Four-deep history of priority-encoder codes, scanned onto a 4-digit seven-segment display.
// Optional macro HIST_HOLD_EN adds a 'hold' input that freezes pushes while scanning continues.
module enc_history_disp #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code_in,
    input  logic       clr,
`ifdef HIST_HOLD_EN
    input  logic       hold,
`endif
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] count
);

    localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

    logic [3:0]  code_q;
    logic [2:0]  slot [4];
    logic [3:0]  slot_vld;
    logic [19:0] presc;
    logic [1:0]  sel;
    logic        hold_act;
    logic        push;
    logic [2:0]  cur_idx;
    logic        cur_vld;

`ifdef HIST_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // A push happens only on the first cycle a new valid code appears.
    assign push = code_in[0] && (code_in != code_q) && !hold_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= 4'b0000;
            slot_vld <= 4'b0000;
            count    <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= 3'd0;
            end
        end else begin
            code_q <= code_in;
            if (clr) begin
                slot_vld <= 4'b0000;
                count    <= 8'd0;
            end else if (push) begin
                slot[3]  <= slot[2];
                slot[2]  <= slot[1];
                slot[1]  <= slot[0];
                slot[0]  <= code_in[3:1];
                slot_vld <= {slot_vld[2:0], 1'b1};
                if (count != 8'd255) begin
                    count <= count + 8'd1;
                end
            end
        end
    end

    // Digit scanning runs independently of history activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= 20'd0;
            sel   <= 2'd0;
        end else if (presc == PRESC_MAX) begin
            presc <= 20'd0;
            sel   <= sel + 2'd1;
        end else begin
            presc <= presc + 20'd1;
        end
    end

    always_comb begin
        cur_idx = slot[sel];
        cur_vld = slot_vld[sel];
        an      = ~(4'b0001 << sel);
        seg     = 7'b1111111;
        if (cur_vld) begin
            case (cur_idx)
                3'd0:    seg = 7'b1000000;
                3'd1:    seg = 7'b1111001;
                3'd2:    seg = 7'b0100100;
                3'd3:    seg = 7'b0110000;
                3'd4:    seg = 7'b0011001;
                3'd5:    seg = 7'b0010010;
                3'd6:    seg = 7'b0000010;
                default: seg = 7'b1111000;
            endcase
        end
    end

endmodule
